// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store memory access unit: access sizes,
// FSM state encoding and the default first-illegal byte address.
package mem_access_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam logic [15:0] ADDR_LIMIT_DEF = 16'hFA00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   // Size code 11 has no meaning and is always rejected.
   function automatic logic size_is_valid(input logic [1:0] s);
      return s != 2'b11;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the memory access unit.
//  - extract: picks the byte/half lane out of a memory word and sign- or
//    zero-extends it (little-endian; byte lane = off, half lane = off[1]).
//  - merge:   replaces the addressed byte/half lane of a memory word with the
//    low byte/half of the store data, leaving the other lanes intact.
module lsu_lane_align
   import mem_access_pkg::*;
(
   input  logic [31:0] i_mem_rd,
   input  logic [15:0] i_wdata,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   output logic [31:0] o_rdata,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [3:0]  w_lane_sel;
   logic [7:0]  w_src [4];

   // Select the addressed byte and halfword from the memory word.
   always_comb begin
      w_byte = i_mem_rd[7:0];
      case (i_off)
         2'b01:   w_byte = i_mem_rd[15:8];
         2'b10:   w_byte = i_mem_rd[23:16];
         2'b11:   w_byte = i_mem_rd[31:24];
         default: w_byte = i_mem_rd[7:0];
      endcase
      w_half = i_off[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
   end

   // Extend the selected lane; words pass through untouched.
   always_comb begin
      o_rdata = i_mem_rd;
      case (i_size)
         SIZE_B:  o_rdata = {{24{w_byte[7] & ~i_uns}}, w_byte};
         SIZE_H:  o_rdata = {{16{w_half[15] & ~i_uns}}, w_half};
         default: o_rdata = i_mem_rd;
      endcase
   end

   // Per byte lane: replace with store data when this lane is addressed.
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_sel[gi] = ((i_size == SIZE_B) && (i_off == 2'(gi))) ||
                              ((i_size == SIZE_H) && (i_off[1] == 1'(gi / 2)));
      assign w_src[gi]      = (i_size == SIZE_H) ? i_wdata[8*(gi%2) +: 8] : i_wdata[7:0];
      assign o_merge[8*gi +: 8] = w_lane_sel[gi] ? w_src[gi] : i_mem_rd[8*gi +: 8];
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns byte/half/word load and store requests into
// word-aligned accesses on a 32-bit word memory. Sub-word stores use a
// read-modify-write; loads are lane-selected and extended. One done pulse
// per request; err with done means the request was rejected and the memory
// was not touched.
// Build option: define MEM_MISALIGN_CHECK_EN to reject halves at odd
// addresses and words whose addr[1:0] != 0 (otherwise the low address bits
// are ignored and the aligned lane is used).
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(ADDR_LIMIT_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_we,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   state_t            r_state;
   state_t            w_state_next;

   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_uns;
   logic              r_we;
   logic              r_err;
   logic [31:0]       r_wdata;
   logic [31:0]       r_merge;
   logic [31:0]       r_rdata;

   logic              w_illegal;
   logic              w_accept;
   logic [31:0]       w_extract;
   logic [31:0]       w_merge;

   assign w_accept = (r_state == ST_IDLE) && req;
   assign mem_a    = {r_addr[ADDR_W-1:2], 2'b00};
   assign rdata    = r_rdata;

   // Decide at request time whether the access is rejected.
   always_comb begin
      w_illegal = !size_is_valid(size) || (addr >= ADDR_LIMIT);
`ifdef MEM_MISALIGN_CHECK_EN
      if ((size == SIZE_H) && addr[0])
         w_illegal = 1'b1;
      if ((size == SIZE_W) && (addr[1:0] != 2'b00))
         w_illegal = 1'b1;
`endif
   end

   lsu_lane_align u_lane (
      .i_mem_rd (mem_rd),
      .i_wdata  (r_wdata[15:0]),
      .i_off    (r_addr[1:0]),
      .i_size   (r_size),
      .i_uns    (r_uns),
      .o_rdata  (w_extract),
      .o_merge  (w_merge)
   );

   // State register; an asynchronous reset drops straight to IDLE so a
   // pending WRITE never reaches the memory.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   // Next-state and per-state outputs.
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b1;
      done         = 1'b0;
      err          = 1'b0;
      mem_we       = 1'b0;
      mem_wd       = 32'h0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (req) begin
               if (w_illegal)
                  w_state_next = ST_DONE;
               else if (we && (size == SIZE_W))
                  w_state_next = ST_WRITE;
               else
                  w_state_next = ST_READ;
            end
         end
         ST_READ: begin
            w_state_next = r_we ? ST_WRITE : ST_DONE;
         end
         ST_WRITE: begin
            mem_we       = 1'b1;
            mem_wd       = (r_size == SIZE_W) ? r_wdata : r_merge;
            w_state_next = ST_DONE;
         end
         ST_DONE: begin
            done         = 1'b1;
            err          = r_err;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Request latches, merge word and load result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr  <= '0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_wdata <= 32'h0;
         r_merge <= 32'h0;
         r_rdata <= 32'h0;
      end else begin
         if (w_accept) begin
            r_addr  <= addr;
            r_size  <= size;
            r_uns   <= uns;
            r_we    <= we;
            r_wdata <= wdata;
            r_err   <= w_illegal;
         end
         if (r_state == ST_READ) begin
            if (r_we)
               r_merge <= w_merge;
            else
               r_rdata <= w_extract;
         end
      end
   end

endmodule
